spi_responder: RTL

- SPI slave (responder) for the far end of the shared SPI wires, used where a DAC/ADC peripheral would sit.
- Lets the kernel-driven masters be looped back and verified in-fabric. It also serves as a generic slave port for host-driven configuration.
- Oversamples the SPI wires on the system clock. Shifts in one WID-bit word per ss_L frame while shifting out a preloaded WID-bit reply.
- Reports completion or abort with single-cycle strobes.

---
 rtl/spi_responder_if.sv | 26 ++
 rtl/spi_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/spi_responder_if.sv
// Bus bundle for spi_responder: the four SPI wires plus the host-side word port.
// The slave modport is the responder's view; master is the driver of the SPI wires.
interface spi_responder_if #(
    parameter int WID = 24
);
    logic           sck;
    logic           ss_L;
    logic           mosi;
    logic           miso;
    logic [WID-1:0] tx_data;
    logic [WID-1:0] rx_data;
    logic           finished;
    logic           aborted;
    logic           overrun;
    logic           busy;

    modport slave (
        input  sck, ss_L, mosi, tx_data,
        output miso, rx_data, finished, aborted, overrun, busy
    );

    modport master (
        output sck, ss_L, mosi, tx_data,
        input  miso, rx_data, finished, aborted, overrun, busy
    );
endinterface

// File: rtl/spi_responder.sv
// Oversampled SPI slave: shifts in one WID-bit word per ss_L frame while
// shifting out a reply latched at frame start; strobes completion or abort.
module spi_responder #(
    parameter int WID      = 24,
    parameter bit POLARITY = 1'b0,
    parameter bit PHASE    = 1'b0
) (
    input  logic           clk,
    input  logic           rst_L,
    spi_responder_if.slave bus
);
    localparam int CW = $clog2(WID + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Synchronisers are left unreset so a reset mid-frame cannot fabricate
    // an ss_L edge from a pin that is still held low.
    logic [2:0] sck_sr;
    logic [2:0] ss_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clk) begin
        sck_sr  <= {sck_sr[1:0], bus.sck};
        ss_sr   <= {ss_sr[1:0], bus.ss_L};
        mosi_sr <= {mosi_sr[0], bus.mosi};
    end

    logic lead_e, trail_e, sample_e, shift_e, ss_fall, ss_rise, mosi_s;

    assign lead_e   = (sck_sr[1] != POLARITY) && (sck_sr[2] == POLARITY);
    assign trail_e  = (sck_sr[1] == POLARITY) && (sck_sr[2] != POLARITY);
    assign sample_e = PHASE ? trail_e : lead_e;
    assign shift_e  = PHASE ? lead_e : trail_e;
    assign ss_fall  = !ss_sr[1] && ss_sr[2];
    assign ss_rise  = ss_sr[1] && !ss_sr[2];
    assign mosi_s   = mosi_sr[1];

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [WID-1:0] tx_shift;
    logic [WID-1:0] rx_shift;
    logic [WID-1:0] rx_word;
    logic           primed;
    logic           miso_q, fin_q, abt_q, ovr_q;

    logic [WID-1:0] rx_next;
    logic           last_bit;

    assign rx_next  = {rx_shift[WID-2:0], mosi_s};
    assign last_bit = (cnt == CW'(WID - 1));

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_word  <= '0;
            primed   <= 1'b0;
            miso_q   <= 1'b0;
            fin_q    <= 1'b0;
            abt_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            abt_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        tx_shift <= bus.tx_data;
                        rx_shift <= '0;
                        cnt      <= '0;
                        ovr_q    <= 1'b0;
                        primed   <= 1'b0;
                        state    <= S_ACTIVE;
                        if (!PHASE) miso_q <= bus.tx_data[WID-1];
                    end
                end
                S_ACTIVE: begin
                    if (sample_e) begin
                        rx_shift <= rx_next;
                        cnt      <= cnt + CW'(1);
                        if (last_bit) begin
                            rx_word <= rx_next;
                            fin_q   <= 1'b1;
                            miso_q  <= 1'b0;
                            // A deselect coinciding with the final sample skips DONE.
                            state   <= ss_rise ? S_IDLE : S_DONE;
                        end
                    end else if (shift_e) begin
                        if (PHASE && !primed) begin
                            primed <= 1'b1;
                            miso_q <= tx_shift[WID-1];
                        end else begin
                            tx_shift <= tx_shift << 1;
                            miso_q   <= tx_shift[WID-2];
                        end
                    end
                    if (ss_rise && !(sample_e && last_bit)) begin
                        abt_q  <= 1'b1;
                        miso_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_DONE: begin
                    miso_q <= 1'b0;
                    if (sample_e) ovr_q <= 1'b1;
                    if (ss_rise) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_word;
    assign bus.finished = fin_q;
    assign bus.aborted  = abt_q;
    assign bus.overrun  = ovr_q;
    assign bus.busy     = (state != S_IDLE);
endmodule
